// File: rtl/aes_channel_arb_pkg.sv
// Shared definitions for the AES channel arbiter: FSM state type, default
// bus widths, the default channel-index type and a modular increment helper.
package aes_channel_arb_pkg;

  localparam int AES_KEY_W       = 128;
  localparam int AES_DATA_W      = 128;
  localparam int AES_DEF_NCH     = 4;
  localparam int AES_DEF_MAX_OUT = 4;

  typedef logic [$clog2(AES_DEF_NCH)-1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_KEY = 2'd1,
    SEND_BLK = 2'd2
  } arb_state_t;

  // (v + 1) mod n, used for the round-robin pointer and FIFO pointers.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/aes_channel_arb_tag.sv
// aes_tag_fifo: synchronous FIFO of channel indices that records which
// channel owns each block in flight at the AES core. Supports push and pop
// in the same cycle at any occupancy, including full and empty.
module aes_tag_fifo
  import aes_channel_arb_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = AES_DEF_MAX_OUT,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             resetH,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Tag storage write port.
  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (resetH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wrap_inc(int'(wr_ptr), DEPTH));
      if (do_pop)  rd_ptr <= PTR_W'(wrap_inc(int'(rd_ptr), DEPTH));
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_channel_arb.sv
// aes_channel_arb: round-robin front end that lets NCH requester channels
// share one AES core. Requests go out as key then block; results come back
// in issue order and are routed to the owning channel via a tag FIFO.
// Optional feature: define AES_ARB_KEY_CACHE_EN to skip resending a key the
// core already holds.
module aes_channel_arb
  import aes_channel_arb_pkg::*;
#(
  parameter int NCH     = AES_DEF_NCH,
  parameter int KEY_W   = AES_KEY_W,
  parameter int DATA_W  = AES_DATA_W,
  parameter int MAX_OUT = AES_DEF_MAX_OUT
) (
  input  logic                          clk,
  input  logic                          resetH,
  input  logic [NCH-1:0]                ch_req_valid,
  input  logic [NCH-1:0][KEY_W-1:0]     ch_req_key,
  input  logic [NCH-1:0][DATA_W-1:0]    ch_req_data,
  output logic [NCH-1:0]                ch_req_ready,
  output logic [NCH-1:0]                ch_rsp_valid,
  output logic [NCH-1:0][DATA_W-1:0]    ch_rsp_data,
  input  logic [NCH-1:0]                ch_rsp_ready,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [KEY_W-1:0]              key_data,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [DATA_W-1:0]             blk_data,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic [DATA_W-1:0]             res_data,
  output logic                          err_orphan
);

  localparam int CH_W  = $clog2(NCH);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  arb_state_t       state;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  grant_idx;
  logic [CH_W-1:0]  pick_idx;
  logic [CH_W-1:0]  scan_idx;
  logic             pick_vld;
  logic             key_hit;
  logic             tag_push;
  logic             tag_pop;
  logic [CH_W-1:0]  head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Round-robin search: lowest channel index at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    // Scan from the farthest offset down so the nearest requester wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      scan_idx = CH_W'((int'(rr_ptr) + k) % NCH);
      if (ch_req_valid[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

`ifdef AES_ARB_KEY_CACHE_EN
  logic [KEY_W-1:0] cache_key;
  logic             cache_vld;

  // Remember the last key the core accepted so a repeated key skips SEND_KEY.
  always_ff @(posedge clk) begin
    if (resetH) begin
      cache_vld <= 1'b0;
      cache_key <= '0;
    end else if (state == SEND_KEY && key_ready) begin
      cache_vld <= 1'b1;
      cache_key <= key_data;
    end
  end

  assign key_hit = cache_vld && (ch_req_key[pick_idx] == cache_key);
`else
  assign key_hit = 1'b0;
`endif

  // Request FSM: grant a channel, present its key, present its block, retire.
  always_ff @(posedge clk) begin
    if (resetH) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      key_valid <= 1'b0;
      blk_valid <= 1'b0;
      key_data  <= '0;
      blk_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld && !fifo_full) begin
            grant_idx <= pick_idx;
            key_data  <= ch_req_key[pick_idx];
            blk_data  <= ch_req_data[pick_idx];
            if (key_hit) begin
              state     <= SEND_BLK;
              blk_valid <= 1'b1;
            end else begin
              state     <= SEND_KEY;
              key_valid <= 1'b1;
            end
          end
        end
        SEND_KEY: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            blk_valid <= 1'b1;
            state     <= SEND_BLK;
          end
        end
        SEND_BLK: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            rr_ptr    <= CH_W'(wrap_inc(int'(grant_idx), NCH));
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tag_push = (state == SEND_BLK) && blk_ready;

  // Acceptance pulse to the granted channel; suppressed while reset is held.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch forms.
    ch_req_ready = '0;
    if (tag_push && !resetH) ch_req_ready[grant_idx] = 1'b1;
  end

  aes_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk       (clk),
    .resetH    (resetH),
    .push      (tag_push),
    .push_data (grant_idx),
    .pop       (tag_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Accept a result only when its owner's register is free or being drained.
  assign res_ready = !fifo_empty && (!ch_rsp_valid[head] || ch_rsp_ready[head]);
  assign tag_pop   = res_valid && res_ready;

  // Per-channel result registers plus the sticky orphan-result flag.
  always_ff @(posedge clk) begin
    if (resetH) begin
      ch_rsp_valid <= '0;
      ch_rsp_data  <= '0;
      err_orphan   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (tag_pop && head == CH_W'(i)) begin
          ch_rsp_valid[i] <= 1'b1;
          ch_rsp_data[i]  <= res_data;
        end else if (ch_rsp_ready[i]) begin
          ch_rsp_valid[i] <= 1'b0;
        end
      end
      // A result with no tags in flight has no owner.
      if (res_valid && fifo_count == '0) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_channel_arb.sv
// Self-checking bench for aes_channel_arb (NCH=4, MAX_OUT=4, 128-bit buses).
// Directed timing/reset/orphan cases, then a transaction-level reference
// model driving queued jobs per channel with randomised handshakes.
module tb_aes_channel_arb;

  localparam int NCH = 4;
  localparam int KW  = 128;
  localparam int DW  = 128;
  localparam int MO  = 4;
`ifdef AES_ARB_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                     clk = 1'b0;
  logic                     resetH;
  logic [NCH-1:0]           ch_req_valid;
  logic [NCH-1:0][KW-1:0]   ch_req_key;
  logic [NCH-1:0][DW-1:0]   ch_req_data;
  logic [NCH-1:0]           ch_req_ready;
  logic [NCH-1:0]           ch_rsp_valid;
  logic [NCH-1:0][DW-1:0]   ch_rsp_data;
  logic [NCH-1:0]           ch_rsp_ready;
  logic                     key_valid, key_ready;
  logic [KW-1:0]            key_data;
  logic                     blk_valid, blk_ready;
  logic [DW-1:0]            blk_data;
  logic                     res_valid, res_ready;
  logic [DW-1:0]            res_data;
  logic                     err_orphan;

  aes_channel_arb #(.NCH(NCH), .KEY_W(KW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk          (clk),
    .resetH       (resetH),
    .ch_req_valid (ch_req_valid),
    .ch_req_key   (ch_req_key),
    .ch_req_data  (ch_req_data),
    .ch_req_ready (ch_req_ready),
    .ch_rsp_valid (ch_rsp_valid),
    .ch_rsp_data  (ch_rsp_data),
    .ch_rsp_ready (ch_rsp_ready),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_data     (key_data),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
  } job_t;

  job_t         jobs [NCH][$];   // per-channel pending requests, head presented
  int           out_q[$];        // owners of blocks issued to the core, in order
  logic [127:0] core_q[$];       // core stand-in results, in issue order
  logic [NCH-1:0] exp_vld;
  logic [127:0] exp_dat [NCH];
  int           m_rr;
  logic         mc_vld;
  logic [127:0] mc_key;
  logic         exp_orphan;
  logic         key_sent;
  int           key_hs_cnt, blk_hs_cnt;
  int           grant_log[$];
  int           hs_mode, res_en, rsp_mode;   // knobs: 0 fixed / 1 random etc.

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0000_ffff_1234_5a5a_0000_ffff_1234;
  endfunction

  function automatic int next_ch();
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = (m_rr + k) % NCH;
      if (jobs[c].size() > 0) return c;
    end
    return -1;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NCH; i++) n += jobs[i].size();
    return n;
  endfunction

  task automatic add_job(input int ch, input logic [127:0] k, input logic [127:0] d);
    job_t j;
    j.key = k;
    j.data = d;
    jobs[ch].push_back(j);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      jobs[i].delete();
      exp_dat[i] = '0;
    end
    out_q.delete();
    core_q.delete();
    grant_log.delete();
    exp_vld = '0;
    m_rr = 0;
    mc_vld = 1'b0;
    mc_key = '0;
    exp_orphan = 1'b0;
    key_sent = 1'b0;
    key_hs_cnt = 0;
    blk_hs_cnt = 0;
  endtask

  task automatic idle_inputs();
    ch_req_valid = '0;
    ch_req_key   = '0;
    ch_req_data  = '0;
    ch_rsp_ready = '0;
    key_ready    = 1'b0;
    blk_ready    = 1'b0;
    res_valid    = 1'b0;
    res_data     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    resetH = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetH = 1'b0;
    model_reset();
  endtask

  // One clock of the model-driven environment: drive, settle, compare, update.
  task automatic cycle();
    int c, c2;
    logic exp_rr, exp_sent;
    logic [NCH-1:0] one;
    logic [127:0] exp_key, exp_blk;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      ch_req_valid[i] = jobs[i].size() > 0;
      ch_req_key[i]   = (jobs[i].size() > 0) ? jobs[i][0].key  : '0;
      ch_req_data[i]  = (jobs[i].size() > 0) ? jobs[i][0].data : '0;
      ch_rsp_ready[i] = (rsp_mode == 2) ? 1'($urandom_range(0, 1)) : (rsp_mode == 1);
    end
    key_ready = (hs_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    blk_ready = (hs_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    res_valid = (res_en != 0) && core_q.size() > 0 && (hs_mode == 0 || $urandom_range(0, 1) == 1);
    res_data  = (core_q.size() > 0) ? core_q[0] : '0;
    #1;
    exp_rr = out_q.size() > 0 && (!exp_vld[out_q[0]] || ch_rsp_ready[out_q[0]]);
    check("res_ready", res_ready, exp_rr);
    check("rsp_valid", ch_rsp_valid, exp_vld);
    check("err_orphan", err_orphan, exp_orphan);
    for (int i = 0; i < NCH; i++)
      if (exp_vld[i]) check("rsp_data", ch_rsp_data[i], exp_dat[i]);
    c = next_ch();
    if (key_valid && key_ready) begin
      key_hs_cnt++;
      exp_key = (c >= 0) ? jobs[c][0].key : 'x;
      check("key_data", key_data, exp_key);
      key_sent = 1'b1;
    end
    // Result side takes effect at this edge; evaluated on pre-edge model state.
    if (res_valid && out_q.size() == 0) exp_orphan = 1'b1;
    for (int i = 0; i < NCH; i++) if (ch_rsp_ready[i]) exp_vld[i] = 1'b0;
    if (res_valid && exp_rr) begin
      c2 = out_q.pop_front();
      exp_vld[c2] = 1'b1;
      exp_dat[c2] = core_q.pop_front();
    end
    for (int i = 0; i < NCH; i++) if (ch_req_ready[i]) grant_log.push_back(i);
    if (blk_valid && blk_ready) begin
      blk_hs_cnt++;
      if (c >= 0) begin
        one = '0;
        one[c] = 1'b1;
        exp_blk = jobs[c][0].data;
        exp_sent = !(CACHE && mc_vld && mc_key == jobs[c][0].key);
      end else begin
        one = 'x;
        exp_blk = 'x;
        exp_sent = 1'bx;
      end
      check("blk_data", blk_data, exp_blk);
      check("req_ready", ch_req_ready, one);
      check("key_sent", key_sent, exp_sent);
      check("grant_cap", int'(out_q.size() < MO), 1);
      if (c >= 0) begin
        if (key_sent) begin
          mc_vld = 1'b1;
          mc_key = jobs[c][0].key;
        end
        core_q.push_back(core_fn(jobs[c][0].key, jobs[c][0].data));
        out_q.push_back(c);
        void'(jobs[c].pop_front());
        m_rr = (c + 1) % NCH;
      end
      key_sent = 1'b0;
    end else begin
      check("req_ready_quiet", ch_req_ready, '0);
    end
  endtask

  task automatic run_until_drained(input int budget, input string tag);
    int n = 0;
    while ((pending() > 0 || out_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, int'(pending() + out_q.size()), 0);
  endtask

  // Hard stop in case something outside the bounded loops stalls.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k0, first_res;
    idle_inputs();
    resetH = 1'b1;
    hs_mode = 0; res_en = 1; rsp_mode = 1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {key_valid, blk_valid, ch_req_ready, ch_rsp_valid, res_ready, err_orphan}, '0);
    @(negedge clk);
    resetH = 1'b0;

    // FIPS-197 single request on channel 2 with zero-wait core.
    ch_req_valid = 4'b0100;
    ch_req_key[2] = FKEY;
    ch_req_data[2] = FPT;
    key_ready = 1'b1;
    blk_ready = 1'b1;
    #1 check("t0_key_valid", key_valid, 0);
    @(negedge clk); #1;
    check("t1_key_valid", key_valid, 1);
    check("t1_key_data", key_data, FKEY);
    check("t1_blk_valid", blk_valid, 0);
    @(negedge clk); #1;
    check("t2_blk_valid", blk_valid, 1);
    check("t2_blk_data", blk_data, FPT);
    check("t2_req_ready", ch_req_ready, 4'b0100);
    @(negedge clk);
    ch_req_valid = '0;
    res_valid = 1'b1;
    res_data = FCT;
    #1;
    check("t3_res_ready", res_ready, 1);
    check("t3_idle", {key_valid, blk_valid, ch_req_ready}, '0);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    check("t4_rsp_valid", ch_rsp_valid, 4'b0100);
    check("t4_rsp_data", ch_rsp_data[2], FCT);

    // Reset while stalled in SEND_BLK, then an orphan result.
    do_reset();
    ch_req_valid = 4'b0001;
    ch_req_key[0] = FPT;
    ch_req_data[0] = FKEY;
    key_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("stall_blk_valid", blk_valid, 1);
    check("stall_no_ready", ch_req_ready, '0);
    @(negedge clk);
    blk_ready = 1'b1;
    resetH = 1'b1;
    #1 check("rst_no_ready", ch_req_ready, '0);
    @(negedge clk);
    resetH = 1'b0;
    idle_inputs();
    #1;
    check("rst_ctrl_zero", {key_valid, blk_valid, ch_req_ready, ch_rsp_valid, res_ready, err_orphan}, '0);
    check("rst_key_zero", key_data, '0);
    check("rst_blk_zero", blk_data, '0);
    check("rst_rsp_zero", 128'(|ch_rsp_data), '0);
    res_valid = 1'b1;
    res_data = 128'hdead;
    #1 check("orphan_res_ready", res_ready, 0);
    @(negedge clk);
    res_valid = 1'b0;
    #1 check("orphan_set", err_orphan, 1);
    repeat (3) @(negedge clk);
    #1 check("orphan_sticky", err_orphan, 1);
    do_reset();
    #1 check("orphan_cleared", err_orphan, 0);

    // Round-robin: every channel busy, grant order must rotate from 0.
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < 3; j++)
        add_job(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    hs_mode = 0; res_en = 1; rsp_mode = 1;
    run_until_drained(400, "rr_drain");
    for (int i = 0; i < 8; i++)
      check("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, i % NCH);

    // Core withholds results: only MAX_OUT blocks may be issued.
    do_reset();
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < 2; j++)
        add_job(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    res_en = 0;
    repeat (60) cycle();
    check("full_inflight", out_q.size(), MO);
    check("full_grants", blk_hs_cnt, MO);
    check("full_idle", {key_valid, blk_valid}, '0);
    res_en = 1;
    run_until_drained(600, "full_drain");

    // Two results for channel 1 with its consumer stalled.
    do_reset();
    k0 = {$urandom, $urandom, $urandom, $urandom};
    add_job(1, k0, 128'h1111);
    add_job(1, ~k0, 128'h2222);
    first_res = core_fn(k0, 128'h1111);
    rsp_mode = 0;
    repeat (40) cycle();
    check("ch1_stall_res_ready", res_ready, 0);
    check("ch1_pending", out_q.size(), 1);
    check("ch1_hold_data", ch_rsp_data[1], first_res);
    rsp_mode = 2;
    run_until_drained(400, "ch1_drain");

    // Same key twice: with the cache the second transaction sends no key.
    do_reset();
    rsp_mode = 1;
    k0 = {$urandom, $urandom, $urandom, $urandom};
    add_job(0, k0, 128'haaaa);
    add_job(1, k0, 128'hbbbb);
    run_until_drained(200, "cache_drain");
    check("cache_key_sends", key_hs_cnt, CACHE ? 1 : 2);

    // Randomised traffic from a small key pool with random handshakes.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      hs_mode = 1; res_en = 1; rsp_mode = 2;
      for (int i = 0; i < NCH; i++) begin
        int n = $urandom_range(0, 6);
        for (int j = 0; j < n; j++)
          add_job(i, 128'(32'hc0de_0000 + $urandom_range(0, 2)), {$urandom, $urandom, $urandom, $urandom});
      end
      run_until_drained(3000, "rand_drain");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
